samp_packetizer: RTL and testbench



---
 rtl/samp_packetizer_if.sv | 21 ++
 rtl/samp_packetizer.sv | 172 +++++++++++++++++
 tb/tb_samp_packetizer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/samp_packetizer_if.sv
// Sample-queue input stream and packet byte output stream, bundled for samp_packetizer.
// master = packetizer side, slave = upstream queue + byte sink side.
interface samp_packetizer_if;
  logic [31:0] samp_stream_data;
  logic [7:0]  samp_stream_count;
  logic        samp_stream_avail;
  logic        samp_stream_pull;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  samp_stream_data, samp_stream_count, samp_stream_avail, out_ready,
    output samp_stream_pull, out_data, out_valid
  );

  modport slave (
    output samp_stream_data, samp_stream_count, samp_stream_avail, out_ready,
    input  samp_stream_pull, out_data, out_valid
  );
endinterface

// File: rtl/samp_packetizer.sv
// Frames 32-bit samples into byte packets: SYNC, seq, N, N*4 payload bytes (LSB first), XOR checksum.
// Partial batches are flushed after FLUSH_CYCLES of waiting in IDLE.
module samp_packetizer #(
  parameter int unsigned MAX_PKT_SAMPLES = 16,
  parameter int unsigned FLUSH_CYCLES    = 1000,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  samp_packetizer_if.master   bus,
  output logic                busy_o,
  output logic [7:0]          seq_num_o
);

  localparam int unsigned     TW      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [7:0]      MAX_N   = 8'(MAX_PKT_SAMPLES);
  localparam logic [TW-1:0]   FLUSH_T = TW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, FETCH, DATA, CSUM} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    gap_q, gap_d;
  logic [7:0]    n_q, n_d;
  logic [7:0]    sent_q, sent_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          pull;
  logic          accept;
  logic          gap_pending;

  assign accept      = out_valid_q && bus.out_ready;
  // Upstream avail/count lag a pull by up to 2 cycles; gap_q masks that window.
  assign gap_pending = (gap_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      gap_q       <= 2'd0;
      n_q         <= 8'd0;
      sent_q      <= 8'd0;
      byte_idx_q  <= 2'd0;
      shift_q     <= 32'd0;
      csum_q      <= 8'd0;
      seq_q       <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      n_q         <= n_d;
      sent_q      <= sent_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      seq_q       <= seq_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    gap_d       = gap_pending ? (gap_q - 2'd1) : gap_q;
    n_d         = n_q;
    sent_d      = sent_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    seq_d       = seq_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pull        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.samp_stream_avail && !gap_pending) begin
          if (bus.samp_stream_count < MAX_N && timer_q != FLUSH_T)
            timer_d = timer_q + TW'(1);
          else
            timer_d = timer_q;
        end
        if (enable_i && !gap_pending && bus.samp_stream_avail &&
            (bus.samp_stream_count >= MAX_N || timer_q == FLUSH_T)) begin
          state_d     = HDR0;
          n_d         = (bus.samp_stream_count >= MAX_N) ? MAX_N : bus.samp_stream_count;
          sent_d      = 8'd0;
          csum_d      = 8'd0;
          timer_d     = '0;
          out_valid_d = 1'b1;
          out_data_d  = SYNC_BYTE;
        end
      end
      HDR0: begin
        if (accept) begin
          state_d    = HDR1;
          out_data_d = seq_q;
        end
      end
      HDR1: begin
        if (accept) begin
          state_d    = HDR2;
          csum_d     = csum_q ^ out_data_q;
          out_data_d = n_q;
        end
      end
      HDR2: begin
        if (accept) begin
          state_d     = FETCH;
          csum_d      = csum_q ^ out_data_q;
          out_valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (bus.samp_stream_avail && !gap_pending) begin
          pull        = 1'b1;
          gap_d       = 2'd2;
          shift_d     = bus.samp_stream_data;
          sent_d      = sent_q + 8'd1;
          byte_idx_d  = 2'd0;
          out_valid_d = 1'b1;
          out_data_d  = bus.samp_stream_data[7:0];
          state_d     = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ out_data_q;
          if (byte_idx_q == 2'd3) begin
            if (sent_q == n_q) begin
              state_d    = CSUM;
              out_data_d = csum_q ^ out_data_q;
            end else begin
              state_d     = FETCH;
              out_valid_d = 1'b0;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = shift_q >> 8;
            out_data_d = shift_q[15:8];
          end
        end
      end
      CSUM: begin
        if (accept) begin
          seq_d       = seq_q + 8'd1;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.samp_stream_pull = pull;
  assign bus.out_data         = out_data_q;
  assign bus.out_valid        = out_valid_q;
  assign busy_o               = (state_q != IDLE);
  assign seq_num_o            = seq_q;

endmodule

// File: tb/tb_samp_packetizer.sv
// Directed bench for samp_packetizer: registered upstream queue model, byte collector, per-packet checks.
// Runs with MAX_PKT_SAMPLES=4 and FLUSH_CYCLES=16.
module tb_samp_packetizer;
  localparam int MAX_N = 4;
  localparam int FLUSH = 16;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic       bp_en  = 1'b0;
  logic       busy;
  logic [7:0] seq_num;

  samp_packetizer_if bus_if();

  samp_packetizer #(
    .MAX_PKT_SAMPLES(MAX_N),
    .FLUSH_CYCLES   (FLUSH),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .bus      (bus_if),
    .busy_o   (busy),
    .seq_num_o(seq_num)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] src[$];
  int          rd_ptr = 0;
  logic [7:0]  rx[$];
  logic [7:0]  exp_q[$];
  int          pulls = 0;
  int          last_pull = -1;
  int          cyc = 0;
  int          valid_seen = 0;
  int          rx_base = 0;
  int          pull_base = 0;
  int          valid_base = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Upstream queue (registered, one-cycle lag after a pull) plus output collector.
  initial begin
    logic       stall_prev;
    logic [7:0] stall_data;
    int         lvl;
    stall_prev = 1'b0;
    stall_data = 8'd0;
    bus_if.samp_stream_avail = 1'b0;
    bus_if.samp_stream_count = 8'd0;
    bus_if.samp_stream_data  = 32'd0;
    bus_if.out_ready         = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_ptr     = src.size();
        last_pull  = -1;
        stall_prev = 1'b0;
      end else begin
        if (bus_if.samp_stream_pull) begin
          check_eq("pull_avail", 32'(src.size() > rd_ptr), 1);
          check_eq("pull_no_valid", bus_if.out_valid, 0);
          if (last_pull >= 0) check_eq("pull_spacing", 32'((cyc - last_pull) >= 5), 1);
          last_pull = cyc;
          pulls++;
          if (rd_ptr < src.size()) rd_ptr++;
        end
        if (stall_prev) begin
          check_eq("stall_valid", bus_if.out_valid, 1);
          check_eq("stall_data", bus_if.out_data, stall_data);
        end
        if (bus_if.out_valid) valid_seen++;
        if (bus_if.out_valid && bus_if.out_ready) rx.push_back(bus_if.out_data);
        stall_prev = bus_if.out_valid && !bus_if.out_ready;
        stall_data = bus_if.out_data;
      end
      @(posedge clk);
      #1;
      lvl = src.size() - rd_ptr;
      bus_if.samp_stream_avail = (lvl > 0);
      bus_if.samp_stream_count = (lvl > 255) ? 8'd255 : 8'(lvl);
      bus_if.samp_stream_data  = (lvl > 0) ? src[rd_ptr] : 32'd0;
      bus_if.out_ready         = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("rst_out_valid", bus_if.out_valid, 0);
    check_eq("rst_out_data", bus_if.out_data, 0);
    check_eq("rst_pull", bus_if.samp_stream_pull, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_seq_num", seq_num, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic mark();
    rx_base    = rx.size();
    pull_base  = pulls;
    valid_base = valid_seen;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && (rx.size() - rx_base) < n; i++) @(negedge clk);
    check_eq(tag, 32'((rx.size() - rx_base) >= n), 1);
  endtask

  task automatic wait_first_valid(output int d);
    d = 0;
    while (!bus_if.out_valid && d < 200) begin
      @(negedge clk);
      if (!bus_if.out_valid) d++;
    end
  endtask

  task automatic check_pkt(input string tag);
    check_eq({tag, "_len"}, 32'((rx.size() - rx_base) >= exp_q.size()), 1);
    for (int i = 0; i < exp_q.size() && (rx_base + i) < rx.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), rx[rx_base + i], exp_q[i]);
    $display("pkt %s bytes=%0d expected=%0d", tag, rx.size() - rx_base, exp_q.size());
  endtask

  task automatic push_n(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) src.push_back(v);
  endtask

  task automatic full_packet(input logic bp, input string tag);
    int d;
    do_reset();
    bp_en  = bp;
    enable = 1'b1;
    mark();
    src.push_back(32'h11111111);
    src.push_back(32'h22222222);
    src.push_back(32'h33333333);
    src.push_back(32'h44444444);
    push_n(32'h55555555, 6);
    wait_first_valid(d);
    check_eq({tag, "_no_timeout"}, 32'(d <= 3), 1);
    exp_q = '{8'hA5, 8'h00, 8'h04};
    for (int s = 1; s <= 4; s++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(s * 8'h11));
    exp_q.push_back(8'h04);
    wait_rx(20, 600, {tag, "_rx"});
    check_pkt(tag);
    check_eq({tag, "_pulls"}, pulls - pull_base, 4);
    bp_en = 1'b0;
  endtask

  initial begin
    int d;
    do_reset();

    // Single sample released only by the flush timeout.
    enable = 1'b1;
    mark();
    src.push_back(32'h04030201);
    wait_first_valid(d);
    check_eq("t1_flush_delay", 32'(d >= FLUSH && d <= FLUSH + 2), 1);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    wait_rx(8, 100, "t1_rx");
    check_pkt("t1");
    repeat (3) @(negedge clk);
    check_eq("t1_pulls", pulls - pull_base, 1);
    check_eq("t1_seq_num", seq_num, 1);

    full_packet(1'b0, "t2");
    full_packet(1'b1, "t3_bp");

    // enable low holds off packets; dropping it mid-packet lets the packet finish.
    do_reset();
    enable = 1'b0;
    mark();
    src.push_back(32'h80000000);
    src.push_back(32'h00400000);
    src.push_back(32'h00002000);
    src.push_back(32'h00000010);
    push_n(32'h00000000, 16);
    repeat (60) @(negedge clk);
    check_eq("t4_dis_pulls", pulls - pull_base, 0);
    check_eq("t4_dis_valid", valid_seen - valid_base, 0);
    enable = 1'b1;
    wait_rx(4, 100, "t4_start");
    check_eq("t4_busy_in_data", busy, 1);
    enable = 1'b0;
    wait_rx(20, 300, "t4_rx");
    repeat (60) @(negedge clk);
    exp_q = '{8'hA5, 8'h00, 8'h04,
              8'h00, 8'h00, 8'h00, 8'h80,
              8'h00, 8'h00, 8'h40, 8'h00,
              8'h00, 8'h20, 8'h00, 8'h00,
              8'h10, 8'h00, 8'h00, 8'h00,
              8'hF4};
    check_pkt("t4");
    check_eq("t4_total_bytes", rx.size() - rx_base, 20);
    check_eq("t4_pulls", pulls - pull_base, 4);
    check_eq("t4_idle", busy, 0);

    // 257 single-sample packets: seq byte wraps FF -> 00.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 257; i++) begin
      mark();
      src.push_back(32'h00000000);
      wait_rx(8, 100, "t5_rx");
      if ((rx.size() - rx_base) >= 8) begin
        check_eq("t5_seq", rx[rx_base + 1], 32'(i & 255));
        check_eq("t5_csum", rx[rx_base + 7], 32'((i & 255) ^ 1));
        $display("pkt t5 seq=%02h csum=%02h", rx[rx_base + 1], rx[rx_base + 7]);
      end
    end
    repeat (3) @(negedge clk);
    check_eq("t5_seq_num_end", seq_num, 1);

    // Reset in the middle of the payload aborts at once.
    do_reset();
    enable = 1'b1;
    mark();
    push_n(32'h11111111, 4);
    wait_rx(5, 100, "t6_in_data");
    check_eq("t6_busy", busy, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", bus_if.out_valid, 0);
    check_eq("t6_rst_pull", bus_if.samp_stream_pull, 0);
    check_eq("t6_rst_seq", seq_num, 0);
    check_eq("t6_rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mark();
    src.push_back(32'hCAFEF00D);
    wait_rx(3, 100, "t6_rx");
    exp_q = '{8'hA5, 8'h00, 8'h01};
    check_pkt("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
